// File: rtl/axi_vram_arbiter_if.sv
// AXI4-Lite channel bundle between the MicroBlaze interconnect and the text VRAM arbiter.
interface axi_vram_arbiter_if #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 16
);
    logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr;
    logic [2:0]                    axi_awprot;
    logic                          axi_awvalid;
    logic                          axi_awready;
    logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata;
    logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb;
    logic                          axi_wvalid;
    logic                          axi_wready;
    logic [1:0]                    axi_bresp;
    logic                          axi_bvalid;
    logic                          axi_bready;
    logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr;
    logic [2:0]                    axi_arprot;
    logic                          axi_arvalid;
    logic                          axi_arready;
    logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata;
    logic [1:0]                    axi_rresp;
    logic                          axi_rvalid;
    logic                          axi_rready;

    modport slave (
        input  axi_awaddr, axi_awprot, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wvalid,
        output axi_wready,
        output axi_bresp, axi_bvalid,
        input  axi_bready,
        input  axi_araddr, axi_arprot, axi_arvalid,
        output axi_arready,
        output axi_rdata, axi_rresp, axi_rvalid,
        input  axi_rready
    );

    modport master (
        output axi_awaddr, axi_awprot, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wvalid,
        input  axi_wready,
        input  axi_bresp, axi_bvalid,
        output axi_bready,
        output axi_araddr, axi_arprot, axi_arvalid,
        input  axi_arready,
        input  axi_rdata, axi_rresp, axi_rvalid,
        output axi_rready
    );
endinterface

// File: rtl/axi_vram_arbiter.sv
// AXI4-Lite slave for the HDMI text controller: VRAM BRAM port plus control/palette registers.
// Define AXI_VRAM_DECERR_EN to answer unmapped accesses with DECERR instead of OKAY.
module axi_vram_arbiter #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 16,
    parameter int VRAM_WORDS       = 1200,
    parameter int REG_BASE         = 2048,
    parameter int NUM_REGS         = 8,
    parameter int BRAM_RD_LAT      = 2
) (
    input  logic                          axi_aclk,
    input  logic                          axi_areset,
    axi_vram_arbiter_if.slave             s_axi,
    output logic                          bram_en,
    output logic [3:0]                    bram_we,
    output logic [$clog2(VRAM_WORDS)-1:0] bram_addr,
    output logic [31:0]                   bram_din,
    input  logic [31:0]                   bram_dout,
    output logic [NUM_REGS*32-1:0]        ctrl_regs
);
    localparam int WORD_W  = C_AXI_ADDR_WIDTH - 2;
    localparam int BRAM_AW = $clog2(VRAM_WORDS);
    localparam int IDX_W   = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_VRAM_DECERR_EN
    localparam logic [1:0] RESP_UNMAPPED = 2'b11;
`else
    localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

    typedef enum logic [2:0] {IDLE, WR, BRESP, RD_WAIT, RRESP} state_t;

    state_t r_state, w_nextState;
    logic   r_lastGrantRead, w_nextLastGrantRead;
    logic [2:0] r_rdCnt;

    logic r_awHeld, r_wHeld, r_arHeld;
    logic r_awReady, r_wReady, r_arReady;
    logic [WORD_W-1:0] r_awWord, r_arWord;
    logic [C_AXI_DATA_WIDTH-1:0] r_wData;
    logic [3:0]  r_wStrb;
    logic [31:0] r_regs [NUM_REGS];
    logic [31:0] r_rdata;
    logic [1:0]  r_bresp, r_rresp;

    logic w_awCap, w_wCap, w_arCap;
    logic w_awHeldNext, w_wHeldNext, w_arHeldNext;
    logic w_wrPend, w_rdPend, w_pickWrite, w_pickRead, w_rdDone;
    logic w_wrVram, w_wrReg, w_rdVram, w_rdReg;
    logic [WORD_W-1:0] w_wrRegOff, w_rdRegOff;
    logic [IDX_W-1:0]  w_wrIdx, w_rdIdx;
    logic w_unused;

    assign w_awCap = s_axi.axi_awvalid & r_awReady;
    assign w_wCap  = s_axi.axi_wvalid  & r_wReady;
    assign w_arCap = s_axi.axi_arvalid & r_arReady;

    // A beat captured this cycle already counts as pending, so the grant cycle follows the capture edge.
    assign w_wrPend    = (r_awHeld | w_awCap) & (r_wHeld | w_wCap);
    assign w_rdPend    = r_arHeld | w_arCap;
    assign w_pickWrite = w_wrPend & (~w_rdPend | r_lastGrantRead);
    assign w_pickRead  = w_rdPend & ~w_pickWrite;

    assign w_awHeldNext = w_awCap | (r_awHeld & (r_state != WR));
    assign w_wHeldNext  = w_wCap  | (r_wHeld  & (r_state != WR));
    assign w_arHeldNext = w_arCap | (r_arHeld & ~w_rdDone);

    assign w_wrVram   = 32'(r_awWord) < VRAM_WORDS;
    assign w_wrReg    = (32'(r_awWord) >= REG_BASE) && (32'(r_awWord) < REG_BASE + NUM_REGS);
    assign w_rdVram   = 32'(r_arWord) < VRAM_WORDS;
    assign w_rdReg    = (32'(r_arWord) >= REG_BASE) && (32'(r_arWord) < REG_BASE + NUM_REGS);
    assign w_wrRegOff = r_awWord - WORD_W'(REG_BASE);
    assign w_rdRegOff = r_arWord - WORD_W'(REG_BASE);
    assign w_wrIdx    = w_wrRegOff[IDX_W-1:0];
    assign w_rdIdx    = w_rdRegOff[IDX_W-1:0];

    assign w_unused = ^{s_axi.axi_awprot, s_axi.axi_arprot, s_axi.axi_awaddr[1:0],
                        s_axi.axi_araddr[1:0], w_wrRegOff, w_rdRegOff};

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_state         <= IDLE;
            r_lastGrantRead <= 1'b1;
            r_rdCnt         <= '0;
        end else begin
            r_state         <= w_nextState;
            r_lastGrantRead <= w_nextLastGrantRead;
            r_rdCnt         <= (r_state == RD_WAIT) ? r_rdCnt + 3'd1 : 3'd0;
        end
    end

    // BRAM strobes are gated by reset so a transaction caught mid-grant never writes.
    always_comb begin
        w_nextState         = r_state;
        w_nextLastGrantRead = r_lastGrantRead;
        w_rdDone            = 1'b0;
        bram_en             = 1'b0;
        bram_we             = 4'h0;
        bram_addr           = r_awWord[BRAM_AW-1:0];
        bram_din            = r_wData[31:0];
        case (r_state)
            IDLE: begin
                if (w_pickWrite) begin
                    w_nextState         = WR;
                    w_nextLastGrantRead = 1'b0;
                end else if (w_pickRead) begin
                    w_nextState         = RD_WAIT;
                    w_nextLastGrantRead = 1'b1;
                end
            end
            WR: begin
                if (w_wrVram && !axi_areset) begin
                    bram_en = 1'b1;
                    bram_we = r_wStrb;
                end
                w_nextState = BRESP;
            end
            BRESP: begin
                if (s_axi.axi_bready) w_nextState = IDLE;
            end
            RD_WAIT: begin
                bram_addr = r_arWord[BRAM_AW-1:0];
                if (r_rdCnt == 3'd0 && w_rdVram && !axi_areset) bram_en = 1'b1;
                if (r_rdCnt == 3'(BRAM_RD_LAT)) begin
                    w_rdDone    = 1'b1;
                    w_nextState = RRESP;
                end
            end
            RRESP: begin
                if (s_axi.axi_rready) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_awHeld  <= 1'b0;
            r_wHeld   <= 1'b0;
            r_arHeld  <= 1'b0;
            r_awReady <= 1'b0;
            r_wReady  <= 1'b0;
            r_arReady <= 1'b0;
            r_awWord  <= '0;
            r_arWord  <= '0;
            r_wData   <= '0;
            r_wStrb   <= '0;
            r_rdata   <= '0;
            r_bresp   <= '0;
            r_rresp   <= '0;
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else begin
            r_awHeld  <= w_awHeldNext;
            r_wHeld   <= w_wHeldNext;
            r_arHeld  <= w_arHeldNext;
            r_awReady <= ~w_awHeldNext;
            r_wReady  <= ~w_wHeldNext;
            r_arReady <= ~w_arHeldNext;
            if (w_awCap) r_awWord <= s_axi.axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
            if (w_arCap) r_arWord <= s_axi.axi_araddr[C_AXI_ADDR_WIDTH-1:2];
            if (w_wCap) begin
                r_wData <= s_axi.axi_wdata;
                r_wStrb <= s_axi.axi_wstrb;
            end
            if (r_state == WR) begin
                if (w_wrReg) begin
                    for (int b = 0; b < 4; b++)
                        if (r_wStrb[b]) r_regs[w_wrIdx][8*b +: 8] <= r_wData[8*b +: 8];
                end
                r_bresp <= (w_wrVram || w_wrReg) ? RESP_OKAY : RESP_UNMAPPED;
            end
            if (w_rdDone) begin
                if (w_rdVram)     r_rdata <= bram_dout;
                else if (w_rdReg) r_rdata <= r_regs[w_rdIdx];
                else              r_rdata <= '0;
                r_rresp <= (w_rdVram || w_rdReg) ? RESP_OKAY : RESP_UNMAPPED;
            end
        end
    end

    assign s_axi.axi_awready = r_awReady;
    assign s_axi.axi_wready  = r_wReady;
    assign s_axi.axi_arready = r_arReady;
    assign s_axi.axi_bvalid  = (r_state == BRESP);
    assign s_axi.axi_bresp   = r_bresp;
    assign s_axi.axi_rvalid  = (r_state == RRESP);
    assign s_axi.axi_rresp   = r_rresp;
    assign s_axi.axi_rdata   = r_rdata;

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_ctrl
        assign ctrl_regs[32*k +: 32] = r_regs[k];
    end
endmodule

// File: tb/tb_axi_vram_arbiter.sv
// Directed bench for axi_vram_arbiter: vector table plus hand-timed handshake sequences.
module tb_axi_vram_arbiter;
`ifdef AXI_VRAM_DECERR_EN
    localparam logic [1:0] UNM = 2'b11;
`else
    localparam logic [1:0] UNM = 2'b00;
`endif

    typedef struct {
        logic        isWrite;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  expResp;
        logic [31:0] expData;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_vram_arbiter_if #(.C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(16)) bus ();

    logic        bramEn;
    logic [3:0]  bramWe;
    logic [10:0] bramAddr;
    logic [31:0] bramDin;
    logic [31:0] bramDout;
    logic [255:0] ctrlRegs;

    axi_vram_arbiter dut (
        .axi_aclk   (clk),
        .axi_areset (rst),
        .s_axi      (bus),
        .bram_en    (bramEn),
        .bram_we    (bramWe),
        .bram_addr  (bramAddr),
        .bram_din   (bramDin),
        .bram_dout  (bramDout),
        .ctrl_regs  (ctrlRegs)
    );

    // Two-cycle BRAM model: en in cycle G gives valid dout in cycle G+2.
    logic [31:0] mem [0:1199];
    logic [31:0] pipe1;
    always @(posedge clk) begin
        if (bramEn) begin
            for (int b = 0; b < 4; b++)
                if (bramWe[b]) mem[bramAddr][8*b +: 8] <= bramDin[8*b +: 8];
            pipe1 <= mem[bramAddr];
        end
        bramDout <= pipe1;
    end

    int total = 0;
    int bad = 0;
    int enCount = 0;
    int enInReset = 0;
    bit grantLog[$];

    always @(posedge clk) begin
        if (bramEn) begin
            if (rst) enInReset++;
            else begin
                enCount++;
                grantLog.push_back(|bramWe);
            end
        end
    end

    vec_t vecs [16];

    function automatic vec_t mkVec(input logic w, input logic [15:0] a, input logic [31:0] d,
                                   input logic [3:0] s, input logic [1:0] r, input logic [31:0] e);
        vec_t v;
        v.isWrite = w; v.addr = a; v.data = d; v.strb = s; v.expResp = r; v.expData = e;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic aRdy, wRdy;
        if (v.isWrite) begin
            bus.axi_awaddr = v.addr; bus.axi_wdata = v.data; bus.axi_wstrb = v.strb;
            bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1;
            for (int i = 0; i < 20 && (bus.axi_awvalid || bus.axi_wvalid); i++) begin
                aRdy = bus.axi_awready; wRdy = bus.axi_wready;
                tick;
                if (aRdy) bus.axi_awvalid = 1'b0;
                if (wRdy) bus.axi_wvalid = 1'b0;
            end
            checkOutput($sformatf("aw/w accepted @%04h", v.addr), {31'b0, bus.axi_awvalid | bus.axi_wvalid}, 0);
            bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
            for (int i = 0; i < 20 && !bus.axi_bvalid; i++) tick;
            checkOutput($sformatf("bvalid @%04h", v.addr), {31'b0, bus.axi_bvalid}, 1);
            checkOutput($sformatf("bresp @%04h", v.addr), {30'b0, bus.axi_bresp}, {30'b0, v.expResp});
            tick;
        end else begin
            bus.axi_araddr = v.addr; bus.axi_arvalid = 1'b1;
            for (int i = 0; i < 20 && bus.axi_arvalid; i++) begin
                aRdy = bus.axi_arready;
                tick;
                if (aRdy) bus.axi_arvalid = 1'b0;
            end
            checkOutput($sformatf("ar accepted @%04h", v.addr), {31'b0, bus.axi_arvalid}, 0);
            bus.axi_arvalid = 1'b0;
            for (int i = 0; i < 20 && !bus.axi_rvalid; i++) tick;
            checkOutput($sformatf("rvalid @%04h", v.addr), {31'b0, bus.axi_rvalid}, 1);
            checkOutput($sformatf("rresp @%04h", v.addr), {30'b0, bus.axi_rresp}, {30'b0, v.expResp});
            checkOutput($sformatf("rdata @%04h", v.addr), bus.axi_rdata, v.expData);
            tick;
        end
    endtask

    initial begin
        int snap;
        vecs[0]  = mkVec(1, 16'h2000, 32'h11223344, 4'hF, 2'b00, 32'h0);
        vecs[1]  = mkVec(1, 16'h2000, 32'hFFAAFFFF, 4'h4, 2'b00, 32'h0);
        vecs[2]  = mkVec(0, 16'h2000, 32'h0,        4'h0, 2'b00, 32'h11AA3344);
        vecs[3]  = mkVec(0, 16'h2007, 32'h0,        4'h0, 2'b00, 32'h00005678);
        vecs[4]  = mkVec(1, 16'h12BC, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0);
        vecs[5]  = mkVec(0, 16'h12BC, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D);
        vecs[6]  = mkVec(1, 16'h0014, 32'hFFFFFFFF, 4'hF, 2'b00, 32'h0);
        vecs[7]  = mkVec(1, 16'h0014, 32'h00000000, 4'h2, 2'b00, 32'h0);
        vecs[8]  = mkVec(0, 16'h0014, 32'h0,        4'h0, 2'b00, 32'hFFFF00FF);
        vecs[9]  = mkVec(1, 16'h201C, 32'h01020304, 4'h9, 2'b00, 32'h0);
        vecs[10] = mkVec(0, 16'h201C, 32'h0,        4'h0, 2'b00, 32'h01000004);
        vecs[11] = mkVec(0, 16'h2020, 32'h0,        4'h0, UNM,   32'h0);
        vecs[12] = mkVec(0, 16'h1FFC, 32'h0,        4'h0, UNM,   32'h0);
        vecs[13] = mkVec(1, 16'h2020, 32'h77777777, 4'hF, UNM,   32'h0);
        vecs[14] = mkVec(0, 16'h0010, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF);
        vecs[15] = mkVec(0, 16'h2004, 32'h0,        4'h0, 2'b00, 32'h00005678);

        for (int i = 0; i < 1200; i++) mem[i] = 32'h0;
        pipe1 = 32'h0;
        bus.axi_awaddr = '0; bus.axi_awprot = '0; bus.axi_awvalid = 1'b0;
        bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wvalid = 1'b0;
        bus.axi_bready = 1'b1;
        bus.axi_araddr = '0; bus.axi_arprot = '0; bus.axi_arvalid = 1'b0;
        bus.axi_rready = 1'b1;

        // Reset held four cycles.
        rst = 1'b1;
        repeat (3) tick;
        checkOutput("awready in reset", {31'b0, bus.axi_awready}, 0);
        checkOutput("wready in reset", {31'b0, bus.axi_wready}, 0);
        checkOutput("arready in reset", {31'b0, bus.axi_arready}, 0);
        checkOutput("bvalid in reset", {31'b0, bus.axi_bvalid}, 0);
        checkOutput("rvalid in reset", {31'b0, bus.axi_rvalid}, 0);
        checkOutput("bram_en in reset", {31'b0, bramEn}, 0);
        tick;
        rst = 1'b0;
        tick;
        checkOutput("awready after reset", {31'b0, bus.axi_awready}, 1);
        checkOutput("wready after reset", {31'b0, bus.axi_wready}, 1);
        checkOutput("arready after reset", {31'b0, bus.axi_arready}, 1);
        checkOutput("ctrl_regs zero", {31'b0, |ctrlRegs}, 0);

        // AW and W together to VRAM word 4.
        bus.axi_awaddr = 16'h0010; bus.axi_wdata = 32'hDEADBEEF; bus.axi_wstrb = 4'hF;
        bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1;
        tick;
        bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
        checkOutput("wr grant bram_en", {31'b0, bramEn}, 1);
        checkOutput("wr grant bram_we", {28'b0, bramWe}, 32'hF);
        checkOutput("wr grant bram_addr", {21'b0, bramAddr}, 32'd4);
        checkOutput("wr grant bram_din", bramDin, 32'hDEADBEEF);
        checkOutput("bvalid in grant", {31'b0, bus.axi_bvalid}, 0);
        tick;
        checkOutput("bvalid after grant", {31'b0, bus.axi_bvalid}, 1);
        checkOutput("bresp vram", {30'b0, bus.axi_bresp}, 0);
        checkOutput("bram_en after grant", {31'b0, bramEn}, 0);
        tick;
        checkOutput("bvalid after bready", {31'b0, bus.axi_bvalid}, 0);

        // W three cycles ahead of AW, register 1.
        snap = enCount;
        bus.axi_wdata = 32'h12345678; bus.axi_wstrb = 4'h3; bus.axi_wvalid = 1'b1;
        tick;
        bus.axi_wvalid = 1'b0;
        checkOutput("wready drops after W", {31'b0, bus.axi_wready}, 0);
        tick; tick;
        checkOutput("wready still low", {31'b0, bus.axi_wready}, 0);
        bus.axi_awaddr = 16'h2004; bus.axi_awvalid = 1'b1;
        tick;
        bus.axi_awvalid = 1'b0;
        tick;
        checkOutput("reg write bvalid", {31'b0, bus.axi_bvalid}, 1);
        checkOutput("reg write bresp", {30'b0, bus.axi_bresp}, 0);
        checkOutput("reg1 merged", ctrlRegs[63:32], 32'h00005678);
        checkOutput("reg write no bram_en", enCount, snap);
        tick;

        // Read word 4 with rready stalled five cycles.
        bus.axi_rready = 1'b0;
        bus.axi_araddr = 16'h0010; bus.axi_arvalid = 1'b1;
        tick;
        bus.axi_arvalid = 1'b0;
        checkOutput("rd grant bram_en", {31'b0, bramEn}, 1);
        checkOutput("rd grant bram_we", {28'b0, bramWe}, 0);
        checkOutput("rd grant bram_addr", {21'b0, bramAddr}, 32'd4);
        tick;
        checkOutput("rvalid grant+1", {31'b0, bus.axi_rvalid}, 0);
        tick;
        checkOutput("rvalid grant+2", {31'b0, bus.axi_rvalid}, 0);
        tick;
        checkOutput("rvalid grant+3", {31'b0, bus.axi_rvalid}, 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall rvalid %0d", i), {31'b0, bus.axi_rvalid}, 1);
            checkOutput($sformatf("stall rdata %0d", i), bus.axi_rdata, 32'hDEADBEEF);
            checkOutput($sformatf("stall rresp %0d", i), {30'b0, bus.axi_rresp}, 0);
            tick;
        end
        bus.axi_rready = 1'b1;
        tick;
        checkOutput("rvalid after rready", {31'b0, bus.axi_rvalid}, 0);

        for (int i = 0; i < 16; i++) applyStimulus(vecs[i]);

        // Unmapped word 1200 never touches the BRAM.
        snap = enCount;
        applyStimulus(mkVec(1, 16'h12C0, 32'hAAAA5555, 4'hF, UNM, 32'h0));
        applyStimulus(mkVec(0, 16'h12C0, 32'h0, 4'h0, UNM, 32'h0));
        checkOutput("unmapped no bram_en", enCount, snap);

        // Reset lands in the write grant cycle.
        bus.axi_awaddr = 16'h0050; bus.axi_wdata = 32'h55AA55AA; bus.axi_wstrb = 4'hF;
        bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1;
        tick;
        bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("bram_en gated by reset", {31'b0, bramEn}, 0);
        tick;
        checkOutput("bvalid after mid reset", {31'b0, bus.axi_bvalid}, 0);
        checkOutput("no write on reset", mem[20], 32'h0);
        tick;
        rst = 1'b0;
        tick;
        grantLog.delete();

        // Write and read pending together twice.
        for (int r = 0; r < 2; r++) begin
            bus.axi_awaddr = 16'h0020; bus.axi_wdata = 32'h00000001 + r; bus.axi_wstrb = 4'hF;
            bus.axi_araddr = 16'h0030;
            bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1; bus.axi_arvalid = 1'b1;
            tick;
            bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0; bus.axi_arvalid = 1'b0;
            repeat (15) tick;
        end
        checkOutput("grant count", grantLog.size(), 4);
        if (grantLog.size() == 4) begin
            checkOutput("grant0 write", {31'b0, grantLog[0]}, 1);
            checkOutput("grant1 read", {31'b0, grantLog[1]}, 0);
            checkOutput("grant2 write", {31'b0, grantLog[2]}, 1);
            checkOutput("grant3 read", {31'b0, grantLog[3]}, 0);
        end
        checkOutput("arb write landed", mem[8], 32'h00000002);
        checkOutput("bram_en during reset", enInReset, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
